// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared ids, states and defaults for the data-memory arbiter
package dmem_arb_pkg;

    localparam int ARB_ADDR_W         = 24;
    localparam int ARB_DATA_W         = 24;
    localparam int ARB_STARVE_MAX_DEF = 8;

    localparam logic ARB_ID_PIPE = 1'b0;
    localparam logic ARB_ID_LDR  = 1'b1;

    typedef enum logic {
        ARB_ST_NORM   = 1'b0,
        ARB_ST_FORCE1 = 1'b1
    } arb_state_t;

endpackage

// File: rtl/dmem_arb_if.sv
// rtl/dmem_arb_if.sv - requester, response and memory-side bundle of the arbiter
interface dmem_arb_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 24
);
    logic              r0_req;
    logic              r0_we;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_gnt;
    logic              r0_rvalid;
    logic [DATA_W-1:0] r0_rdata;

    logic              r1_req;
    logic              r1_we;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_gnt;
    logic              r1_rvalid;
    logic [DATA_W-1:0] r1_rdata;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        input  mem_rdata,
        output r0_gnt, r0_rvalid, r0_rdata,
        output r1_gnt, r1_rvalid, r1_rdata,
        output mem_we, mem_addr, mem_wdata,
        output stall
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        output r1_req, r1_we, r1_addr, r1_wdata,
        output mem_rdata,
        input  r0_gnt, r0_rvalid, r0_rdata,
        input  r1_gnt, r1_rvalid, r1_rdata,
        input  mem_we, mem_addr, mem_wdata,
        input  stall
    );
endinterface

// File: rtl/arb_tag_pipe.sv
// rtl/arb_tag_pipe.sv - DEPTH-deep {valid, id} shift register tracking reads in flight
module arb_tag_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic clr_n,
    input  logic in_valid,
    input  logic in_id,
    output logic out_valid,
    output logic out_id
);
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] id_q;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            valid_q <= '0;
            id_q    <= '0;
        end else begin
            valid_q[0] <= in_valid;
            id_q[0]    <= in_valid & in_id;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                id_q[i]    <= id_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_id    = id_q[DEPTH-1];
endmodule

// File: rtl/dmem_arb.sv
// rtl/dmem_arb.sv - pipeline-priority arbiter for data-memory port 0 with loader anti-starvation
module dmem_arb
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = ARB_ADDR_W,
    parameter int DATA_W     = ARB_DATA_W,
    parameter int STARVE_MAX = ARB_STARVE_MAX_DEF,
    parameter int MEM_LAT    = 1
) (
    input  logic      iw_clk,
    input  logic      iw_rst_n,
    dmem_arb_if.slave bus
);
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    arb_state_t state, state_next;
    logic [7:0] cnt, cnt_next;
    logic       gnt0, gnt1;
    logic       push_valid, push_id;
    logic       tail_valid, tail_id;

    always_ff @(posedge iw_clk) begin
        if (!iw_rst_n) begin
            state <= ARB_ST_NORM;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        case (state)
            ARB_ST_NORM: begin
                if (bus.r0_req)      gnt0 = 1'b1;
                else if (bus.r1_req) gnt1 = 1'b1;
                // a grant in the same cycle the limit would be hit takes precedence
                if (!bus.r1_req || gnt1)     cnt_next = '0;
                else if (cnt < STARVE_LIM)   cnt_next = cnt + 8'd1;
                if (cnt_next == STARVE_LIM)  state_next = ARB_ST_FORCE1;
            end
            ARB_ST_FORCE1: begin
                gnt1       = bus.r1_req;
                cnt_next   = '0;
                state_next = ARB_ST_NORM;
            end
            default: state_next = ARB_ST_NORM;
        endcase
        if (!iw_rst_n) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    assign bus.r0_gnt = gnt0;
    assign bus.r1_gnt = gnt1;
    assign bus.stall  = iw_rst_n & bus.r0_req & ~gnt0;

    always_comb begin
        bus.mem_we    = 1'b0;
        bus.mem_addr  = {ADDR_W{1'b0}};
        bus.mem_wdata = {DATA_W{1'b0}};
        if (gnt0) begin
            bus.mem_we    = bus.r0_we;
            bus.mem_addr  = bus.r0_addr;
            bus.mem_wdata = bus.r0_wdata;
        end else if (gnt1) begin
            bus.mem_we    = bus.r1_we;
            bus.mem_addr  = bus.r1_addr;
            bus.mem_wdata = bus.r1_wdata;
        end
    end

    assign push_valid = (gnt0 & ~bus.r0_we) | (gnt1 & ~bus.r1_we);
    assign push_id    = gnt1 ? ARB_ID_LDR : ARB_ID_PIPE;

    arb_tag_pipe #(.DEPTH(MEM_LAT)) u_tag_pipe (
        .clk       (iw_clk),
        .clr_n     (iw_rst_n),
        .in_valid  (push_valid),
        .in_id     (push_id),
        .out_valid (tail_valid),
        .out_id    (tail_id)
    );

    assign bus.r0_rvalid = iw_rst_n & tail_valid & (tail_id == ARB_ID_PIPE);
    assign bus.r1_rvalid = iw_rst_n & tail_valid & (tail_id == ARB_ID_LDR);
    assign bus.r0_rdata  = bus.r0_rvalid ? bus.mem_rdata : {DATA_W{1'b0}};
    assign bus.r1_rdata  = bus.r1_rvalid ? bus.mem_rdata : {DATA_W{1'b0}};
endmodule

// File: tb/tb_dmem_arb.sv
// tb/tb_dmem_arb.sv - self-checking bench for dmem_arb against a behavioural arbitration model
module tb_dmem_arb;
    localparam int MEM_LAT    = 1;
    localparam int STARVE_MAX = 8;

    typedef struct {
        bit          v;
        bit          id;
        logic [23:0] d;
    } resp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arb_if #(.ADDR_W(24), .DATA_W(24)) bus ();

    dmem_arb #(.ADDR_W(24), .DATA_W(24), .STARVE_MAX(STARVE_MAX), .MEM_LAT(MEM_LAT)) dut (
        .iw_clk   (clk),
        .iw_rst_n (rst_n),
        .bus      (bus)
    );

    logic [23:0] mem [0:63];
    logic [23:0] rd_q;
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
        rd_q <= mem[bus.mem_addr[5:0]];
    end
    assign bus.mem_rdata = rd_q;

    int          total = 0;
    int          passed = 0;
    logic [23:0] shadow [0:63];
    resp_t       pend[$];
    int          streak = 0;
    bit          force_pend = 1'b0;
    bit          last_e0, last_e1;
    logic        o_g1, o_rv0, o_rv1;
    logic [23:0] o_rd0, o_rd1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic reset_model();
        streak     = 0;
        force_pend = 1'b0;
        pend.delete();
        for (int i = 0; i < MEM_LAT; i++) pend.push_back('{v: 1'b0, id: 1'b0, d: 24'h0});
    endtask

    // One clock: drive, check combinational outputs at negedge, advance the model.
    task automatic cycle(input bit rs, input bit q0, input bit w0, input logic [5:0] a0,
                         input logic [23:0] d0, input bit q1, input bit w1,
                         input logic [5:0] a1, input logic [23:0] d1);
        bit          e0, e1, ewe;
        logic [23:0] eaddr, ewd;
        resp_t       pe;
        rst_n        = rs;
        bus.r0_req   = q0; bus.r0_we = w0; bus.r0_addr = {18'h0, a0}; bus.r0_wdata = d0;
        bus.r1_req   = q1; bus.r1_we = w1; bus.r1_addr = {18'h0, a1}; bus.r1_wdata = d1;
        pe = pend.pop_front();
        e0 = 1'b0; e1 = 1'b0;
        if (rs) begin
            if (force_pend) e1 = q1;
            else if (q0)    e0 = 1'b1;
            else            e1 = q1;
        end
        ewe = 1'b0; eaddr = 24'h0; ewd = 24'h0;
        if (e0) begin ewe = w0; eaddr = {18'h0, a0}; ewd = d0; end
        if (e1) begin ewe = w1; eaddr = {18'h0, a1}; ewd = d1; end
        if (!rs) pe.v = 1'b0;
        @(negedge clk);
        o_g1 = bus.r1_gnt; o_rv0 = bus.r0_rvalid; o_rv1 = bus.r1_rvalid;
        o_rd0 = bus.r0_rdata; o_rd1 = bus.r1_rdata;
        chk("r0_gnt", {31'h0, bus.r0_gnt}, {31'h0, e0});
        chk("r1_gnt", {31'h0, bus.r1_gnt}, {31'h0, e1});
        chk("stall", {31'h0, bus.stall}, {31'h0, rs & q0 & ~e0});
        chk("mem_we", {31'h0, bus.mem_we}, {31'h0, ewe});
        chk("mem_addr", {8'h0, bus.mem_addr}, {8'h0, eaddr});
        chk("mem_wdata", {8'h0, bus.mem_wdata}, {8'h0, ewd});
        chk("r0_rvalid", {31'h0, bus.r0_rvalid}, {31'h0, pe.v & ~pe.id});
        chk("r1_rvalid", {31'h0, bus.r1_rvalid}, {31'h0, pe.v & pe.id});
        chk("r0_rdata", {8'h0, bus.r0_rdata}, (pe.v && !pe.id) ? {8'h0, pe.d} : 32'h0);
        chk("r1_rdata", {8'h0, bus.r1_rdata}, (pe.v && pe.id) ? {8'h0, pe.d} : 32'h0);
        if (!rs) begin
            reset_model();
        end else begin
            if (e0 && !w0) pend.push_back('{v: 1'b1, id: 1'b0, d: shadow[a0]});
            else if (e1 && !w1) pend.push_back('{v: 1'b1, id: 1'b1, d: shadow[a1]});
            else pend.push_back('{v: 1'b0, id: 1'b0, d: 24'h0});
            if (e0 && w0) shadow[a0] = d0;
            if (e1 && w1) shadow[a1] = d1;
            if (force_pend) begin
                force_pend = 1'b0;
                streak     = 0;
            end else if (q1 && !e1) begin
                streak++;
                if (streak >= STARVE_MAX) force_pend = 1'b1;
            end else begin
                streak = 0;
            end
        end
        last_e0 = e0; last_e1 = e1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          slots[$];
        int          seq[$];
        bit          h0, hw0, h1, hw1;
        logic [5:0]  ha0, ha1;
        logic [23:0] hd0, hd1;
        reset_model();
        @(posedge clk);
        #1;
        cycle(0, 1, 0, 6'd1, 24'h1, 1, 1, 6'd2, 24'h2);
        cycle(0, 1, 1, 6'd3, 24'h3, 1, 0, 6'd4, 24'h4);

        // Loader preloads every word; addr 0x10 holds 0x00ABCD.
        for (int a = 0; a < 64; a++)
            cycle(1, 0, 0, 6'd0, 24'h0, 1, 1, 6'(a), (a == 16) ? 24'h00ABCD : 24'($urandom));

        cycle(1, 1, 0, 6'h10, 24'h0, 0, 0, 6'd0, 24'h0);
        cycle(1, 0, 0, 6'h00, 24'h0, 0, 0, 6'd0, 24'h0);
        chk("r0_first_read", {7'h0, o_rv0, o_rd0}, {7'h0, 1'b1, 24'h00ABCD});
        chk("r0_first_read_r1", {31'h0, o_rv1}, 32'h0);

        for (int i = 0; i < 18; i++) begin
            cycle(1, 1, 0, 6'($urandom_range(0, 63)), 24'h0, 1, 0, 6'd9, 24'h0);
            if (o_g1) slots.push_back(i);
        end
        chk("starve_slots_n", slots.size(), 2);
        chk("starve_slot_a", slots[0], 8);
        chk("starve_slot_b", slots[1], 17);
        cycle(1, 0, 0, 6'd0, 24'h0, 0, 0, 6'd0, 24'h0);

        cycle(1, 0, 0, 6'd0, 24'h0, 1, 1, 6'd5, 24'h000111);
        cycle(1, 0, 0, 6'd0, 24'h0, 1, 0, 6'd5, 24'h0);
        cycle(1, 0, 0, 6'd0, 24'h0, 0, 0, 6'd0, 24'h0);
        chk("r1_readback", {7'h0, o_rv1, o_rd1}, {7'h0, 1'b1, 24'h000111});

        cycle(1, 1, 0, 6'd1, 24'h0, 0, 0, 6'd0, 24'h0);
        cycle(1, 0, 0, 6'd0, 24'h0, 1, 0, 6'd2, 24'h0);
        seq.push_back({o_rv1, o_rv0});
        cycle(1, 1, 0, 6'd3, 24'h0, 0, 0, 6'd0, 24'h0);
        seq.push_back({o_rv1, o_rv0});
        cycle(1, 0, 0, 6'd0, 24'h0, 0, 0, 6'd0, 24'h0);
        seq.push_back({o_rv1, o_rv0});
        chk("alt_route", {seq[0][1:0], seq[1][1:0], seq[2][1:0]}, 32'b01_10_01);

        cycle(1, 1, 0, 6'd7, 24'h0, 0, 0, 6'd0, 24'h0);
        cycle(0, 0, 0, 6'd0, 24'h0, 0, 0, 6'd0, 24'h0);
        cycle(1, 0, 0, 6'd0, 24'h0, 0, 0, 6'd0, 24'h0);
        chk("post_reset_rvalid", {30'h0, o_rv1, o_rv0}, 32'h0);
        slots.delete();
        for (int i = 0; i < 9; i++) begin
            cycle(1, 1, 0, 6'd8, 24'h0, 1, 0, 6'd9, 24'h0);
            if (o_g1) slots.push_back(i);
        end
        chk("post_reset_force", (slots.size() == 1) ? slots[0] : -1, 8);

        // Streak reaches 7, then r0 drops: the ordinary grant must clear it.
        for (int i = 0; i < 7; i++) cycle(1, 1, 0, 6'd10, 24'h0, 1, 0, 6'd11, 24'h0);
        cycle(1, 0, 0, 6'd0, 24'h0, 1, 0, 6'd11, 24'h0);
        slots.delete();
        for (int i = 0; i < 9; i++) begin
            cycle(1, 1, 0, 6'd12, 24'h0, 1, 0, 6'd13, 24'h0);
            if (o_g1) slots.push_back(i);
        end
        chk("grant_beats_limit", (slots.size() == 1) ? slots[0] : -1, 8);

        h0 = 1'b0; h1 = 1'b0; hw0 = 1'b0; hw1 = 1'b0;
        ha0 = '0; ha1 = '0; hd0 = '0; hd1 = '0;
        for (int i = 0; i < 400; i++) begin
            if (!h0 || last_e0) begin
                h0 = ($urandom_range(0, 3) != 0); hw0 = $urandom_range(0, 1) == 1;
                ha0 = 6'($urandom_range(0, 63)); hd0 = 24'($urandom);
            end
            if (!h1 || last_e1) begin
                h1 = ($urandom_range(0, 4) != 0); hw1 = $urandom_range(0, 1) == 1;
                ha1 = 6'($urandom_range(0, 63)); hd1 = 24'($urandom);
            end
            cycle(($urandom_range(0, 99) != 0), h0, hw0, ha0, hd0, h1, hw1, ha1, hd1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/dmem_arb.md
Name: dmem_arb

Overview:
- Arbiter sharing data-memory port 0 between two requesters: requester 0 is the pipeline's MA/MO stages, requester 1 is a loader/debug agent (program/data preload, state dump).
- Sits between the stages and the mem instance.
- Pipeline wins by default; a starvation counter guarantees the loader forward progress.
- When the pipeline loses arbitration, the block raises a stall request that feeds the hazard unit.
- Read responses are tagged and returned to the requester that issued them, after the memory's fixed read latency.

Parameters:
- ADDR_W, 24, address width; must equal `SIZE_ADDR.
- DATA_W, 24, data width; must equal `SIZE_DATA.
- STARVE_MAX, 8, consecutive denied cycles of requester 1 before it is forced to win; legal range 1..255.
- MEM_LAT, 1, memory read latency in cycles, from address issue to rdata valid; legal range 1..4.

Ports:
- iw_clk  in  1  clock; all state updates on the rising edge.
- iw_rst_n  in  1  reset; synchronous, active-low.
- iw_r0_req  in  1  pipeline access request.
- iw_r0_we  in  1  pipeline write enable (1 = write, 0 = read).
- iw_r0_addr  in  ADDR_W  pipeline address.
- iw_r0_wdata  in  DATA_W  pipeline write data.
- ow_r0_gnt  out  1  pipeline request accepted this cycle.
- ow_r0_rvalid  out  1  pipeline read data valid.
- ow_r0_rdata  out  DATA_W  pipeline read data.
- iw_r1_req  in  1  loader access request.
- iw_r1_we  in  1  loader write enable.
- iw_r1_addr  in  ADDR_W  loader address.
- iw_r1_wdata  in  DATA_W  loader write data.
- ow_r1_gnt  out  1  loader request accepted this cycle.
- ow_r1_rvalid  out  1  loader read data valid.
- ow_r1_rdata  out  DATA_W  loader read data.
- ow_mem_we  out  1  memory write enable.
- ow_mem_addr  out  ADDR_W  memory address.
- ow_mem_wdata  out  DATA_W  memory write data.
- iw_mem_rdata  in  DATA_W  memory read data.
- ow_stall  out  1  pipeline stall request: iw_r0_req=1 and ow_r0_gnt=0.

Behaviour:
- Handshake
  - Each requester holds req/we/addr/wdata stable until it sees gnt=1 in the same cycle.
  - Transfer occurs on any cycle where req=1 and gnt=1.
  - gnt is combinational from req and the registered arbitration state.
  - At most one gnt per cycle.
- Memory side
  - ow_mem_* combinationally mirror the granted requester's fields.
  - With no grant: ow_mem_we=0, ow_mem_addr=0, ow_mem_wdata=0.
  - A write never asserts rvalid.
- FSM
  - ST_NORM
    - r0 wins whenever iw_r0_req=1; otherwise r1 wins if iw_r1_req=1.
    - Starvation counter (8 bit) increments on each cycle with iw_r1_req=1 and ow_r1_gnt=0.
    - The counter clears on any r1 grant or when iw_r1_req=0.
    - When the counter reaches STARVE_MAX at a clock edge, the next state is ST_FORCE1.
  - ST_FORCE1
    - r1 wins unconditionally if iw_r1_req=1; r0 is denied and ow_stall=1.
    - Exactly one r1 grant, then return to ST_NORM with the counter cleared.
    - If iw_r1_req has dropped (illegal, tolerated), return to ST_NORM immediately with no grant to anyone that cycle.
- Response path
  - Tag shift register, MEM_LAT deep; each entry is {valid, id}.
  - A granted read pushes {1, id}; a write or idle cycle pushes {0, x}.
  - At the tail, valid routes iw_mem_rdata to ow_rN_rdata with ow_rN_rvalid=1 for one cycle.
  - The non-selected rdata output holds 0.
  - Back-to-back reads, alternating or same requester, are returned in issue order with no bubbles.
- Reset (iw_rst_n=0 at an edge)
  - State goes to ST_NORM, counter to 0, all tag entries invalid.
  - In-flight reads are dropped: no rvalid after reset.
  - While iw_rst_n=0, all gnt, rvalid, rdata, ow_mem_* and ow_stall are forced to 0 combinationally.
- Simultaneous events
  - Counter reaching STARVE_MAX on the same cycle r1 is granted: the grant wins, the counter clears, and the FSM stays in ST_NORM.
- Width rules
  - No arithmetic on addresses or data; pure muxing.
  - The counter saturates at STARVE_MAX and never wraps.

Decomposition:
- Shared package/header (arb.vh alongside sizes.vh):
  - requester id constants ARB_ID_PIPE=0 and ARB_ID_LDR=1;
  - state encodings ARB_ST_NORM and ARB_ST_FORCE1;
  - default STARVE_MAX.
- One sub-module: arb_tag_pipe, a parameterised MEM_LAT-deep {valid, id} shift register with synchronous active-low clear.
- Top of dmem_arb holds the FSM, the counter and the muxes.

Test Plan:
- Reset, then r0 read to addr 0x000010 with memory preloaded 0x00ABCD:
  - ow_r0_gnt=1 in the same cycle;
  - ow_r0_rvalid=1 with rdata=0x00ABCD exactly MEM_LAT=1 cycle later;
  - ow_r1_rvalid stays 0.
- r0 and r1 both requesting every cycle, STARVE_MAX=8:
  - r0 is granted on cycles 0-7 and r1 on cycle 8, with ow_stall=1 on cycle 8;
  - the pattern repeats with period 9.
- r1 alone: writes 0x000111 to addr 5, then reads addr 5:
  - gnt=1 on both cycles;
  - ow_mem_we=1 only on the write;
  - ow_r1_rvalid=1 with rdata=0x000111 on the cycle after the read.
- Alternating reads r0@1, r1@2, r0@3 on consecutive cycles:
  - three consecutive rvalid pulses, routed r0, r1, r0 with the matching data.
- r0 read granted, then iw_rst_n=0 on the next edge:
  - no rvalid is ever produced;
  - after release: FSM in ST_NORM, counter 0, ow_stall=0 with no requests.
- Counter at 7 (STARVE_MAX=8) while iw_r0_req drops, so r1 is granted that cycle:
  - counter clears to 0 and the FSM stays in ST_NORM, with no forced cycle following.
